// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing round-robin arbiter.
// The grant-hold feature in the top is enabled by the REGARB_LOCK_EN macro.
package reg_share_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_W  = 2;
  localparam int DEF_CW = 8;
  localparam int IDW    = $clog2(DEF_N);

  // Index is sized for the largest supported requester count (8).
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  // Scan from ptr+1 upward with wraparound; the first active request wins.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !p.vld) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          p.vld = 1'b1;
          p.idx = j[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
// The LOCK signal exists only when REGARB_LOCK_EN is defined.
interface reg_share_arbiter_if
  import reg_share_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) ();

  localparam int IDW_L = $clog2(N);

  logic [N-1:0]     REQ;
  logic [N*W-1:0]   DATA;
`ifdef REGARB_LOCK_EN
  logic [N-1:0]     LOCK;
`endif
  logic [N-1:0]     GNT;
  logic [W-1:0]     O;
  logic             WR_PULSE;
  logic [IDW_L-1:0] LAST_ID;
  logic [CW-1:0]    WR_COUNT;

`ifdef REGARB_LOCK_EN
  modport master (
    output REQ, DATA, LOCK,
    input  GNT, O, WR_PULSE, LAST_ID, WR_COUNT
  );
  modport slave (
    input  REQ, DATA, LOCK,
    output GNT, O, WR_PULSE, LAST_ID, WR_COUNT
  );
`else
  modport master (
    output REQ, DATA,
    input  GNT, O, WR_PULSE, LAST_ID, WR_COUNT
  );
  modport slave (
    input  REQ, DATA,
    output GNT, O, WR_PULSE, LAST_ID, WR_COUNT
  );
`endif

endinterface

// File: rtl/reg_share_arbiter_reg_word.sv
// W-bit shared storage word: plain D flip-flops with write enable
// and asynchronous active-high clear.
module reg_word #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester per cycle write access to a shared
// register; optional grant hold (atomic bursts) with REGARB_LOCK_EN.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input logic                 CLK,
  input logic                 RESET,
  reg_share_arbiter_if.slave  bus
);

  localparam int IDW_L = $clog2(N);

  logic [IDW_L-1:0] r_ptr;
  logic [IDW_L-1:0] r_last_id;
  logic             r_wr_pulse;
  logic [CW-1:0]    r_wr_count;

  pick_t            w_pick;
  logic             w_hold;
  logic             w_gvld;
  logic [2:0]       w_gidx;
  logic [W-1:0]     w_wdata;
  logic [W-1:0]     w_o;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_pick = rr_pick(8'(bus.REQ), 3'(r_ptr), N);

  // A locked last writer keeps the register regardless of rotation.
`ifdef REGARB_LOCK_EN
  assign w_hold = bus.REQ[r_last_id] & bus.LOCK[r_last_id];
`else
  assign w_hold = 1'b0;
`endif

  assign w_gvld  = w_hold | w_pick.vld;
  assign w_gidx  = w_hold ? 3'(r_last_id) : w_pick.idx;
  // Only the granted slice is selected, so X on other requesters never reaches O.
  assign w_wdata = bus.DATA[w_gidx*W +: W];

  assign bus.GNT = w_gvld ? (N'(1) << w_gidx) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr      <= IDW_L'(N - 1);
      r_last_id  <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_wr_pulse <= w_gvld;
      if (w_gvld) begin
        r_ptr      <= IDW_L'(w_gidx);
        r_last_id  <= IDW_L'(w_gidx);
        r_wr_count <= sat_inc(r_wr_count);
      end
    end
  end

  reg_word #(.W(W)) u_word (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_we  (w_gvld),
    .i_d   (w_wdata),
    .o_q   (w_o)
  );

  assign bus.O        = w_o;
  assign bus.WR_PULSE = r_wr_pulse;
  assign bus.LAST_ID  = r_last_id;
  assign bus.WR_COUNT = r_wr_count;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N=4, W=2) with a CW=2 instance for
// counter saturation; the burst test is built when REGARB_LOCK_EN is defined.
module tb_reg_share_arbiter;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_mis;

  reg_share_arbiter_if #(.N(4), .W(2), .CW(8)) bus  ();
  reg_share_arbiter_if #(.N(4), .W(2), .CW(2)) bus2 ();

  reg_share_arbiter #(.N(4), .W(2), .CW(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  reg_share_arbiter #(.N(4), .W(2), .CW(2)) dut_c2 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus2)
  );

  assign bus2.REQ  = bus.REQ;
  assign bus2.DATA = bus.DATA;
`ifdef REGARB_LOCK_EN
  assign bus2.LOCK = bus.LOCK;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RESET = 1'b1;
    bus.REQ  = '0;
    bus.DATA = '0;
`ifdef REGARB_LOCK_EN
    bus.LOCK = '0;
`endif

    // Reset state, then idle after release
    tick();
    check("rst_O", 32'(bus.O), 0);
    check("rst_cnt", 32'(bus.WR_COUNT), 0);
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_O", 32'(bus.O), 0);
      check("idle_GNT", 32'(bus.GNT), 0);
      check("idle_cnt", 32'(bus.WR_COUNT), 0);
      check("idle_last", 32'(bus.LAST_ID), 0);
      check("idle_pulse", 32'(bus.WR_PULSE), 0);
    end

    // Single write from requester 0; X on the other slices
    bus.REQ  = 4'b0001;
    bus.DATA = {6'bxxxxxx, 2'b10};
    #1;
    check("single_GNT", 32'(bus.GNT), 32'h1);
    tick();
    bus.REQ  = '0;
    bus.DATA = '0;
    #1;
    check("single_O", 32'(bus.O), 32'h2);
    check("single_pulse", 32'(bus.WR_PULSE), 1);
    check("single_last", 32'(bus.LAST_ID), 0);
    check("single_cnt", 32'(bus.WR_COUNT), 1);
    check("single_GNT0", 32'(bus.GNT), 0);
    tick();
    check("pulse_drop", 32'(bus.WR_PULSE), 0);
    check("hold_O", 32'(bus.O), 32'h2);

    // Reset pulse, then all requesting: strict rotation from requester 0
    RESET = 1'b1;
    #1;
    check("pulse_rst_O", 32'(bus.O), 0);
    RESET = 1'b0;
    bus.REQ  = 4'b1111;
    bus.DATA = 8'b11_10_01_00;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rot_GNT", 32'(bus.GNT), 32'(1 << (k % 4)));
      check("rot_cnt", 32'(bus.WR_COUNT), 32'(k));
      check("sat_cnt", 32'(bus2.WR_COUNT), 32'((k < 3) ? k : 3));
      if (k > 0) begin
        check("rot_O", 32'(bus.O), 32'((k - 1) % 4));
        check("rot_pulse", 32'(bus.WR_PULSE), 1);
      end
      tick();
    end
    bus.REQ = '0;
    #1;
    check("rot_O_last", 32'(bus.O), 3);
    check("rot_cnt8", 32'(bus.WR_COUNT), 8);
    check("rot_lastid", 32'(bus.LAST_ID), 3);
    check("sat_cnt_end", 32'(bus2.WR_COUNT), 3);
    tick();
    check("idle_keep_O", 32'(bus.O), 3);
    check("idle_keep_cnt", 32'(bus.WR_COUNT), 8);

    // Asynchronous reset mid-cycle with a write pending
    bus.REQ  = 4'b0001;
    bus.DATA = 8'b00_00_00_01;
    #1;
    RESET = 1'b1;
    #1;
    check("async_O", 32'(bus.O), 0);
    check("async_cnt", 32'(bus.WR_COUNT), 0);
    check("async_last", 32'(bus.LAST_ID), 0);
    tick();
    check("async_nowr_O", 32'(bus.O), 0);
    check("async_nowr_pulse", 32'(bus.WR_PULSE), 0);
    RESET = 1'b0;
    #1;
    tick();
    check("rel_O", 32'(bus.O), 1);
    check("rel_cnt", 32'(bus.WR_COUNT), 1);
    check("rel_pulse", 32'(bus.WR_PULSE), 1);

    // Sparse requests skip idle requesters and alternate fairly
    bus.REQ  = 4'b1010;
    bus.DATA = 8'b10_00_11_00;
    #1;
    check("skip_GNT1", 32'(bus.GNT), 32'h2);
    tick();
    check("skip_O1", 32'(bus.O), 3);
    check("skip_last1", 32'(bus.LAST_ID), 1);
    check("skip_GNT3", 32'(bus.GNT), 32'h8);
    tick();
    check("skip_O3", 32'(bus.O), 2);
    check("skip_last3", 32'(bus.LAST_ID), 3);
    check("skip_GNTwrap", 32'(bus.GNT), 32'h2);
    check("skip_cnt", 32'(bus.WR_COUNT), 3);
    bus.REQ = '0;
    tick();

`ifdef REGARB_LOCK_EN
    // Locked burst by requester 0, then rotation resumes at requester 1
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    bus.REQ  = 4'b0011;
    bus.LOCK = 4'b0001;
    bus.DATA = 8'b00_00_01_10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lock_GNT", 32'(bus.GNT), 32'h1);
      tick();
    end
    bus.LOCK = '0;
    #1;
    check("unlock_GNT", 32'(bus.GNT), 32'h2);
    check("lock_O", 32'(bus.O), 2);
    tick();
    check("unlock_O", 32'(bus.O), 1);
    check("lock_cnt", 32'(bus.WR_COUNT), 4);
    bus.REQ = '0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register, a bank of plain D flip-flops, between N requesters.
- Each cycle at most one requester is granted; its data is written into the register at the next CLK rising edge.
- Sits between board-level sources (switch/header inputs, counters) and the shared register that drives LEDs/outputs.
- Also reports the last writer and a saturating write count.

Parameters:
- N, 4, number of requesters (2..8).
- W, 2, data width of the shared register.
- CW, 8, width of the write counter.

Ports:
- CLK  input  1  rising-edge clock for all state.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  N  per-requester write request; level, held until granted.
- DATA  input  N*W  packed write data; requester i occupies bits [i*W +: W].
- LOCK  input  N  per-requester grant hold; present only with REGARB_LOCK_EN.
- GNT  output  N  one-hot grant, combinational from REQ and pointer; all zero when idle.
- O  output  W  current shared register contents.
- WR_PULSE  output  1  high for one cycle after the register was written.
- LAST_ID  output  clog2(N)  index of the most recent writer.
- WR_COUNT  output  CW  number of writes since reset, saturating.

Behaviour:
- Clocking and reset:
  - One clock domain, CLK. RESET is asynchronous and active-high.
  - While RESET is high, all registered state clears immediately: O=0, WR_PULSE=0, LAST_ID=0, WR_COUNT=0, pointer PTR=N-1.
  - With PTR=N-1 after reset, requester 0 has first priority.
- Arbitration (combinational):
  - Search from index (PTR+1) mod N upward, wrapping through N-1 back to 0.
  - The first i with REQ[i]=1 receives GNT[i]=1. If REQ=0, then GNT=0.
- Write (registered, on the CLK edge when |GNT):
  - O <= DATA[g*W +: W], LAST_ID <= g, PTR <= g, WR_PULSE <= 1.
  - WR_COUNT <= WR_COUNT+1, saturating at 2^CW-1 (holds at max, no wrap).
- Idle edge (no grant): O, LAST_ID, PTR and WR_COUNT hold; WR_PULSE <= 0.
- Latency:
  - Grant in cycle t; O, LAST_ID and WR_PULSE are valid in cycle t+1.
  - A requester sees its own data on O one cycle after GNT.
- Handshake: a requester drops REQ[i] in the cycle after GNT[i]=1. If REQ[i] stays high, it is treated as a new request and re-arbitrated fairly.
- Fairness: with all N requesters continuously requesting, grants rotate 0,1,...,N-1,0 with no gaps. Worst-case wait is N-1 cycles.
- Simultaneous events:
  - REQ changes in the same cycle as a grant: the grant is decided purely on the current REQ and PTR.
  - RESET asserted mid-cycle discards the pending write.
  - RESET deasserted: the first edge after release may already write.
- DATA of non-granted requesters is ignored. X on non-granted DATA must not propagate to O.

Optional Feature:
- Macro: REGARB_LOCK_EN.
- Defined:
  - The LOCK port exists.
  - If the last writer (LAST_ID=k) has REQ[k]=1 and LOCK[k]=1, it is granted again regardless of rotation, starting an atomic burst.
  - The burst ends the first cycle LOCK[k] or REQ[k] is low. Arbitration then resumes from PTR=k.
  - WR_COUNT counts every burst write.
- Not defined: no LOCK port; pure round-robin as above.

Decomposition:
- Package reg_share_pkg:
  - default N, W, CW;
  - localparam IDW = clog2(N);
  - function rr_pick(req, ptr) returning a grant index and a valid bit.
- Sub-module reg_word:
  - W-bit register with async active-high RESET and write enable;
  - holds O and is instantiated once.
- The arbiter, pointer and counter stay in the top.

Test Plan:
- Release RESET with no REQ -> O=0, GNT=0, WR_COUNT=0, LAST_ID=0 for 5 cycles.
- REQ=0001, DATA[0]=2'b10, one cycle -> GNT=0001 the same cycle; next cycle O=2'b10, WR_PULSE=1, LAST_ID=0, WR_COUNT=1.
- REQ=1111 held 8 cycles, DATA[i]=i -> GNT sequence 0001,0010,0100,1000 repeated twice; O follows 0,1,2,3,0,1,2,3 delayed one cycle; WR_COUNT=8.
- CW=2, continuous REQ for 6 cycles -> WR_COUNT stops at 3.
- Assert RESET asynchronously mid-cycle with O=2'b11 -> O=0 before the next edge; no write occurs on that edge.
- With REGARB_LOCK_EN: REQ=0011, LOCK=0001 for 3 cycles -> GNT=0001 three times; when LOCK drops, the next grant is 0010.
